// File: rtl/seq_sub_pkg.sv
// Shared types and helpers for the sequential slice-wise subtractor.
package seq_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } seq_sub_state_t;

   // Slice counter width; a single-slice build still needs one bit.
   function automatic int unsigned cnt_width(input int unsigned n, input int unsigned k);
      int unsigned s;
      s = n / k;
      return (s <= 1) ? 1 : $clog2(s);
   endfunction

endpackage

// File: rtl/sub_slice.sv
// K-bit ripple subtractor: d = a - b - bin, built as a + ~b + ~bin on full-adder cells.
module sub_slice #(
   parameter int unsigned K = 8
) (
   input  logic [K-1:0] i_a,
   input  logic [K-1:0] i_b,
   input  logic         i_bin,
   output logic [K-1:0] o_d,
   output logic         o_bout
);

   logic [K:0]   w_c;
   logic [K-1:0] w_bn;

   assign w_c[0] = ~i_bin;
   assign w_bn   = ~i_b;

   for (genvar i = 0; i < K; i++) begin : g_fa
      assign o_d[i]     = i_a[i] ^ w_bn[i] ^ w_c[i];
      assign w_c[i + 1] = (i_a[i] & w_bn[i]) | (w_c[i] & (i_a[i] ^ w_bn[i]));
   end

   // No carry out of the top means the slice needed to borrow.
   assign o_bout = ~w_c[K];

endmodule

// File: rtl/seq_subtractor.sv
// Multi-cycle subtractor, one K-bit slice per clock, LS slice first, start/ready/done handshake.
// Optional signed-overflow output enabled by defining SEQ_SUB_OVF_EN.
module seq_subtractor
   import seq_sub_pkg::*;
#(
   parameter int unsigned N = 32,
   parameter int unsigned K = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic [N-1:0] i_x,
   input  logic [N-1:0] i_y,
   input  logic         i_bin,
   output logic         o_ready,
   output logic         o_done,
   output logic [N-1:0] o_diff,
   output logic         o_bout
`ifdef SEQ_SUB_OVF_EN
   ,
   output logic         o_ovf
`endif
);

   localparam int unsigned S  = N / K;
   localparam int unsigned CW = cnt_width(N, K);
   localparam logic [CW-1:0] LastCnt = CW'(S - 1);

   seq_sub_state_t r_state, w_state_next;
   logic [CW-1:0]  r_cnt;
   logic           r_borrow;
   logic [N-1:0]   r_x, r_y, r_work, r_diff;
   logic           r_bout;
   logic [N-1:0]   w_x_next, w_y_next, w_work_next;
   logic [K-1:0]   w_d;
   logic           w_bout;
   logic           w_last;

   sub_slice #(.K(K)) u_slice (
      .i_a    (r_x[K-1:0]),
      .i_b    (r_y[K-1:0]),
      .i_bin  (r_borrow),
      .o_d    (w_d),
      .o_bout (w_bout)
   );

   // Results enter from the MSB end so the final slice lands in the top bits.
   if (K < N) begin : g_shift
      assign w_x_next    = {{K{1'b0}}, r_x[N-1:K]};
      assign w_y_next    = {{K{1'b0}}, r_y[N-1:K]};
      assign w_work_next = {w_d, r_work[N-1:K]};
   end else begin : g_single
      assign w_x_next    = '0;
      assign w_y_next    = '0;
      assign w_work_next = w_d;
   end

   assign w_last = (r_cnt == LastCnt);

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (i_start) w_state_next = CALC;
         CALC:    if (w_last)  w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt    <= '0;
         r_borrow <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
         r_work   <= '0;
         r_diff   <= '0;
         r_bout   <= 1'b0;
      end else begin
         if (r_state == IDLE && i_start) begin
            r_x      <= i_x;
            r_y      <= i_y;
            r_borrow <= i_bin;
            r_cnt    <= '0;
         end else if (r_state == CALC) begin
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_borrow <= w_bout;
            r_work   <= w_work_next;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
               r_diff <= w_work_next;
               r_bout <= w_bout;
            end
         end
      end
   end

`ifdef SEQ_SUB_OVF_EN
   // Operand sign bits are kept aside because the operand registers shift away.
   logic r_x_msb, r_y_msb, r_ovf;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_x_msb <= 1'b0;
         r_y_msb <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (r_state == IDLE && i_start) begin
         r_x_msb <= i_x[N-1];
         r_y_msb <= i_y[N-1];
      end else if (r_state == CALC && w_last) begin
         r_ovf <= (r_x_msb != r_y_msb) && (w_work_next[N-1] != r_x_msb);
      end
   end

   assign o_ovf = r_ovf;
`endif

   assign o_ready = (r_state == IDLE);
   assign o_done  = (r_state == DONE);
   assign o_diff  = r_diff;
   assign o_bout  = r_bout;

endmodule

// File: tb/tb_seq_subtractor.sv
// Self-checking bench for seq_subtractor (N=32, K=8) against an arithmetic reference model.
module tb_seq_subtractor;

   localparam int unsigned N = 32;
   localparam int unsigned K = 8;
   localparam int unsigned S = N / K;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [N-1:0] x, y;
   logic         bin;
   logic         ready, done, bout;
   logic [N-1:0] diff;
   logic         ovf;

   int checks;
   int errors;

   seq_subtractor #(.N(N), .K(K)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_start (start),
      .i_x     (x),
      .i_y     (y),
      .i_bin   (bin),
      .o_ready (ready),
      .o_done  (done),
      .o_diff  (diff),
      .o_bout  (bout)
`ifdef SEQ_SUB_OVF_EN
      ,
      .o_ovf   (ovf)
`endif
   );

`ifndef SEQ_SUB_OVF_EN
   assign ovf = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {ovf, bout, diff} from wide unsigned arithmetic and operand signs.
   function automatic logic [N+1:0] ref_sub(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic bi);
      logic [N:0] t;
      logic       ov;
      t  = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bi};
      ov = (a[N-1] != b[N-1]) && (t[N-1] != a[N-1]);
`ifndef SEQ_SUB_OVF_EN
      ov = 1'b0;
`endif
      return {ov, t[N], t[N-1:0]};
   endfunction

   // One handshake; returns observed outputs, edges to done, and ready violations.
   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi,
                        output logic [N-1:0] d, output logic bo, output logic ov,
                        output int lat, output int rdy_bad);
      @(negedge clk);
      x = a; y = b; bin = bi; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      x = $urandom; y = $urandom; bin = 1'($urandom);
      lat = 0;
      rdy_bad = 0;
      while (done !== 1'b1 && lat < 50) begin
         if (ready !== 1'b0) rdy_bad++;
         @(negedge clk);
         lat++;
      end
      if (ready !== 1'b0) rdy_bad++;
      d  = diff;
      bo = bout;
      ov = ovf;
      @(negedge clk);
      if (ready !== 1'b1) rdy_bad++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; x = '0; y = '0; bin = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (ready !== 1'b1 || done !== 1'b0 || diff !== '0 || bout !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset: ready=%b done=%b diff=%h bout=%b ovf=%b, need 1 0 0 0 0",
                  ready, done, diff, bout, ovf);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_and_check(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic bi);
      logic [N-1:0] d;
      logic         bo, ov;
      int           lat, rb;
      logic [N+1:0] e;
      e = ref_sub(a, b, bi);
      do_op(a, b, bi, d, bo, ov, lat, rb);
      checks++;
      if (d !== e[N-1:0] || bo !== e[N] || ov !== e[N+1]) begin
         errors++;
         $display("FAIL %s result: diff=%h bout=%b ovf=%b, need %h %b %b",
                  name, d, bo, ov, e[N-1:0], e[N], e[N+1]);
      end
      checks++;
      if (lat != int'(S) || rb != 0) begin
         errors++;
         $display("FAIL %s timing: done after %0d edges, ready faults %0d, need %0d and 0",
                  name, lat, rb, S);
      end
   endtask

   task automatic test_directed();
      run_and_check("sub_100_58", 32'd100, 32'd58, 1'b0);
      run_and_check("sub_0_1", 32'd0, 32'd1, 1'b0);
      run_and_check("sub_min_1", 32'h8000_0000, 32'd1, 1'b0);
      run_and_check("sub_5_5_b1", 32'd5, 32'd5, 1'b1);
      run_and_check("sub_max_min", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         run_and_check("random", $urandom, $urandom, 1'($urandom));
      end
   endtask

   task automatic test_start_ignored();
      int           ndone;
      logic [N-1:0] d;
      ndone = 0;
      d = '0;
      @(negedge clk);
      x = 32'd10; y = 32'd3; bin = 1'b0; start = 1'b1;
      @(negedge clk);            // after edge 0
      start = 1'b0;
      @(negedge clk);            // after edge 1
      x = 32'd99; y = 32'd1; start = 1'b1;
      @(negedge clk);            // after edge 2
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (done === 1'b1) begin
            ndone++;
            d = diff;
         end
         @(negedge clk);
      end
      checks++;
      if (ndone != 1 || d !== 32'd7) begin
         errors++;
         $display("FAIL start_ignored: done pulses=%0d diff=%0d, need 1 and 7", ndone, d);
      end
   endtask

   task automatic test_reset_mid();
      int ndone;
      ndone = 0;
      @(negedge clk);
      x = 32'd10; y = 32'd3; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b1 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: ready=%b done=%b diff=%h bout=%b, need 1 0 0 0",
                  ready, done, diff, bout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_after: done pulses=%0d ready=%b, need 0 and 1", ndone, ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] ox[0:20];
      logic [N-1:0] oy[0:20];
      logic         ob[0:20];
      logic [N+1:0] e;
      int           ndone;
      ndone = 0;
      @(negedge clk);
      ox[0] = $urandom; oy[0] = $urandom; ob[0] = 1'($urandom);
      x = ox[0]; y = oy[0]; bin = ob[0]; start = 1'b1;
      for (int ed = 0; ed < 20; ed++) begin
         @(negedge clk);         // after edge ed
         if (done === 1'b1) begin
            ndone++;
            checks++;
            if (ed != 4 && ed != 10 && ed != 16) begin
               errors++;
               $display("FAIL b2b_timing: done after edge %0d, need 4, 10 or 16", ed);
            end else begin
               e = ref_sub(ox[ed - 4], oy[ed - 4], ob[ed - 4]);
               checks++;
               if (diff !== e[N-1:0] || bout !== e[N] || ovf !== e[N+1]) begin
                  errors++;
                  $display("FAIL b2b_result edge %0d: diff=%h bout=%b ovf=%b, need %h %b %b",
                           ed, diff, bout, ovf, e[N-1:0], e[N], e[N+1]);
               end
            end
         end
         ox[ed + 1] = $urandom; oy[ed + 1] = $urandom; ob[ed + 1] = 1'($urandom);
         x = ox[ed + 1]; y = oy[ed + 1]; bin = ob[ed + 1];
         start = (ed + 1 <= 12);
      end
      checks++;
      if (ndone != 3) begin
         errors++;
         $display("FAIL b2b_count: done pulses=%0d, need 3", ndone);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_directed();
      test_random();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
